// File: rtl/note_pkg.sv
// Shared note-code types, semitone boundary table and MIDI-key-to-note-code encoding
// for the pitch-to-note path.
package note_pkg;

    localparam logic [2:0] NOTE_LETTER_A = 3'd0;
    localparam logic [2:0] NOTE_LETTER_B = 3'd1;
    localparam logic [2:0] NOTE_LETTER_C = 3'd2;
    localparam logic [2:0] NOTE_LETTER_D = 3'd3;
    localparam logic [2:0] NOTE_LETTER_E = 3'd4;
    localparam logic [2:0] NOTE_LETTER_F = 3'd5;
    localparam logic [2:0] NOTE_LETTER_G = 3'd6;

    localparam logic [1:0] ACC_NATURAL = 2'b01;
    localparam logic [1:0] ACC_FLAT    = 2'b10;

    localparam int BOUND_W    = 20;
    localparam int MIDI_MIN   = 21;
    localparam int MIDI_MAX   = 108;
    localparam int NUM_BOUNDS = MIDI_MAX - MIDI_MIN + 1;

    // Result value used by the stability filter for an out-of-range sample.
    localparam logic [6:0] KEY_NONE = 7'd0;

    typedef struct packed {
        logic [2:0] letter;
        logic [1:0] acc;
        logic [2:0] octave;
    } note_code_t;

    // Lower edge of each key in 1/16 Hz: round(16*440*2^((k-69)/12 - 1/24)), k = 21..108.
    localparam logic [BOUND_W-1:0] BOUNDARY_TABLE [NUM_BOUNDS] = '{
        20'd427,   20'd453,   20'd480,   20'd508,   20'd539,   20'd571,   20'd605,   20'd640,
        20'd679,   20'd719,   20'd762,   20'd807,   20'd855,   20'd906,   20'd960,   20'd1017,
        20'd1077,  20'd1141,  20'd1209,  20'd1281,  20'd1357,  20'd1438,  20'd1523,  20'd1614,
        20'd1710,  20'd1812,  20'd1919,  20'd2033,  20'd2154,  20'd2282,  20'd2418,  20'd2562,
        20'd2714,  20'd2876,  20'd3047,  20'd3228,  20'd3420,  20'd3623,  20'd3839,  20'd4067,
        20'd4309,  20'd4565,  20'd4836,  20'd5124,  20'd5429,  20'd5751,  20'd6093,  20'd6456,
        20'd6840,  20'd7246,  20'd7677,  20'd8134,  20'd8617,  20'd9130,  20'd9673,  20'd10248,
        20'd10857, 20'd11503, 20'd12187, 20'd12911, 20'd13679, 20'd14493, 20'd15354, 20'd16267,
        20'd17235, 20'd18259, 20'd19345, 20'd20496, 20'd21714, 20'd23006, 20'd24374, 20'd25823,
        20'd27358, 20'd28985, 20'd30709, 20'd32535, 20'd34469, 20'd36519, 20'd38691, 20'd40991,
        20'd43429, 20'd46011, 20'd48747, 20'd51646, 20'd54717, 20'd57970, 20'd61417, 20'd65069
    };

    // Accidentals are always spelled as flats.
    function automatic note_code_t midi_to_note_code(input logic [6:0] key);
        note_code_t code;
        logic [3:0] pc;
        pc          = 4'(key % 7'd12);
        code.octave = 3'(key / 7'd12 - 7'd1);
        code.acc    = ACC_NATURAL;
        case (pc)
            4'd0:    code.letter = NOTE_LETTER_C;
            4'd1:    begin code.letter = NOTE_LETTER_D; code.acc = ACC_FLAT; end
            4'd2:    code.letter = NOTE_LETTER_D;
            4'd3:    begin code.letter = NOTE_LETTER_E; code.acc = ACC_FLAT; end
            4'd4:    code.letter = NOTE_LETTER_E;
            4'd5:    code.letter = NOTE_LETTER_F;
            4'd6:    begin code.letter = NOTE_LETTER_G; code.acc = ACC_FLAT; end
            4'd7:    code.letter = NOTE_LETTER_G;
            4'd8:    begin code.letter = NOTE_LETTER_A; code.acc = ACC_FLAT; end
            4'd9:    code.letter = NOTE_LETTER_A;
            4'd10:   begin code.letter = NOTE_LETTER_B; code.acc = ACC_FLAT; end
            default: code.letter = NOTE_LETTER_B;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/note_boundary_rom.sv
// Combinational MIDI key -> lower boundary lookup with two independent read ports.
module note_boundary_rom
    import note_pkg::*;
(
    input  logic [6:0]         key_a_i,
    input  logic [6:0]         key_b_i,
    output logic [BOUND_W-1:0] bound_a_o,
    output logic [BOUND_W-1:0] bound_b_o
);

    // Keys outside the table read as zero rather than aliasing onto a real entry.
    function automatic logic [BOUND_W-1:0] lookup(input logic [6:0] key);
        if (key < 7'(MIDI_MIN) || key > 7'(MIDI_MAX)) begin
            return '0;
        end
        return BOUNDARY_TABLE[7'(key - 7'(MIDI_MIN))];
    endfunction

    always_comb begin
        bound_a_o = lookup(key_a_i);
        bound_b_o = lookup(key_b_i);
    end

endmodule

// File: rtl/note_tracker.sv
// Quantises an integer-Hz frequency to the nearest semitone by iterative binary search,
// then commits the note once the same result has been seen STABLE_COUNT times in a row.
module note_tracker
    import note_pkg::*;
#(
    parameter int FREQ_W       = 16,
    parameter int LOW_KEY      = 57,
    parameter int NUM_KEYS     = 27,
    parameter int STABLE_COUNT = 3
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              freq_valid_in,
    input  logic [FREQ_W-1:0] freq_in,
    output logic              freq_ready_out,
    output logic              raw_valid_out,
    output logic [6:0]        raw_midi_out,
    output logic              raw_oor_out,
    output logic              note_valid_out,
    output logic [7:0]        note_code_out,
    output logic [6:0]        midi_out,
    output logic              note_changed_out
);

    localparam int STEPS  = $clog2(NUM_KEYS);
    localparam int STEP_W = $clog2(STEPS + 1);
    localparam int CNT_W  = $clog2(STABLE_COUNT + 1);
    localparam int CMP_W  = (FREQ_W + 4 > BOUND_W) ? FREQ_W + 4 : BOUND_W;
    localparam int HI_KEY = LOW_KEY + NUM_KEYS;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_SEARCH = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    if (LOW_KEY < MIDI_MIN || HI_KEY > MIDI_MAX || NUM_KEYS < 2 || STABLE_COUNT < 1) begin : g_bad_params
        $error("note_tracker: key window must lie within 21..108 and STABLE_COUNT must be >= 1");
    end

    logic [1:0]        state_q, state_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              oor_q, oor_d;
    logic [6:0]        lo_q, lo_d, hi_q, hi_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              raw_valid_q, raw_valid_d;
    logic [6:0]        raw_midi_q, raw_midi_d;
    logic              raw_oor_q, raw_oor_d;
    logic [6:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              note_valid_q, note_valid_d;
    logic [6:0]        midi_q, midi_d;
    note_code_t        code_q, code_d;
    logic              changed_q, changed_d;

    logic [CMP_W-1:0]   f16;
    logic [6:0]         mid;
    logic [6:0]         rom_key_a;
    logic [BOUND_W-1:0] bound_a, bound_b;
    logic [6:0]         result;

    assign f16       = CMP_W'({freq_q, 4'b0000});
    assign mid       = 7'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
    assign rom_key_a = (state_q == ST_CHECK) ? 7'(LOW_KEY) : mid;
    assign result    = oor_q ? KEY_NONE : lo_q;

    // Port A serves the lower range edge in CHECK and the probe key in SEARCH.
    note_boundary_rom u_rom (
        .key_a_i   (rom_key_a),
        .key_b_i   (7'(HI_KEY)),
        .bound_a_o (bound_a),
        .bound_b_o (bound_b)
    );

    always_comb begin
        state_d      = state_q;
        freq_d       = freq_q;
        oor_d        = oor_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        step_d       = step_q;
        raw_valid_d  = 1'b0;
        raw_midi_d   = raw_midi_q;
        raw_oor_d    = raw_oor_q;
        cand_d       = cand_q;
        count_d      = count_q;
        note_valid_d = note_valid_q;
        midi_d       = midi_q;
        code_d       = code_q;
        changed_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (freq_valid_in) begin
                    freq_d  = freq_in;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                oor_d   = (f16 < CMP_W'(bound_a)) || (f16 >= CMP_W'(bound_b));
                lo_d    = 7'(LOW_KEY);
                hi_d    = 7'(HI_KEY);
                step_d  = '0;
                state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                if ((hi_q - lo_q) > 7'd1) begin
                    if (f16 >= CMP_W'(bound_a)) lo_d = mid;
                    else                        hi_d = mid;
                end
                step_d = step_q + 1'b1;
                if (step_q == STEP_W'(STEPS - 1)) state_d = ST_DONE;
            end
            default: begin
                state_d     = ST_IDLE;
                raw_valid_d = 1'b1;
                raw_midi_d  = result;
                raw_oor_d   = oor_q;
                if (result == cand_q) begin
                    count_d = (count_q == CNT_W'(STABLE_COUNT)) ? count_q : count_q + 1'b1;
                end else begin
                    cand_d  = result;
                    count_d = CNT_W'(1);
                end
                if (count_d == CNT_W'(STABLE_COUNT) && (result != midi_q || !note_valid_q)) begin
                    if (result != KEY_NONE) begin
                        note_valid_d = 1'b1;
                        midi_d       = result;
                        code_d       = midi_to_note_code(result);
                        changed_d    = 1'b1;
                    end else if (note_valid_q) begin
                        note_valid_d = 1'b0;
                        midi_d       = '0;
                        code_d       = '0;
                        changed_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            freq_q       <= '0;
            oor_q        <= 1'b0;
            lo_q         <= '0;
            hi_q         <= '0;
            step_q       <= '0;
            raw_valid_q  <= 1'b0;
            raw_midi_q   <= '0;
            raw_oor_q    <= 1'b0;
            cand_q       <= '0;
            count_q      <= '0;
            note_valid_q <= 1'b0;
            midi_q       <= '0;
            code_q       <= '0;
            changed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            freq_q       <= freq_d;
            oor_q        <= oor_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            step_q       <= step_d;
            raw_valid_q  <= raw_valid_d;
            raw_midi_q   <= raw_midi_d;
            raw_oor_q    <= raw_oor_d;
            cand_q       <= cand_d;
            count_q      <= count_d;
            note_valid_q <= note_valid_d;
            midi_q       <= midi_d;
            code_q       <= code_d;
            changed_q    <= changed_d;
        end
    end

    assign freq_ready_out   = (state_q == ST_IDLE);
    assign raw_valid_out    = raw_valid_q;
    assign raw_midi_out     = raw_midi_q;
    assign raw_oor_out      = raw_oor_q;
    assign note_valid_out   = note_valid_q;
    assign note_code_out    = code_q;
    assign midi_out         = midi_q;
    assign note_changed_out = changed_q;

endmodule

// File: tb/tb_note_tracker.sv
// Directed scoreboard bench for note_tracker with default parameters (STABLE_COUNT = 3).
module tb_note_tracker;

    // Handshake: a sample is taken on the rising edge where freq_valid_in && freq_ready_out;
    // each accepted sample yields exactly one raw_valid_out pulse 7 cycles later.
    typedef struct packed {
        logic [6:0] raw;
        logic       oor;
        logic       valid;
        logic [7:0] code;
        logic [6:0] midi;
        logic       chg;
    } exp_t;

    logic        clk_in;
    logic        rst_n_in;
    logic        freq_valid_in;
    logic [15:0] freq_in;
    logic        freq_ready_out;
    logic        raw_valid_out;
    logic [6:0]  raw_midi_out;
    logic        raw_oor_out;
    logic        note_valid_out;
    logic [7:0]  note_code_out;
    logic [6:0]  midi_out;
    logic        note_changed_out;

    logic [24:0] exp_q[$];
    int          acc_q[$];
    int          checks;
    int          errors;
    int          cycle;
    int          prev_acc;
    bit          have_prev;

    note_tracker dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .freq_valid_in    (freq_valid_in),
        .freq_in          (freq_in),
        .freq_ready_out   (freq_ready_out),
        .raw_valid_out    (raw_valid_out),
        .raw_midi_out     (raw_midi_out),
        .raw_oor_out      (raw_oor_out),
        .note_valid_out   (note_valid_out),
        .note_code_out    (note_code_out),
        .midi_out         (midi_out),
        .note_changed_out (note_changed_out)
    );

    // ---------------- clock / reset ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial cycle = 0;
    always @(posedge clk_in) cycle <= cycle + 1;

    // ---------------- stimulus table ----------------
    // freq, raw_midi, raw_oor, note_valid, note_code, midi, note_changed
    int vec [24][7] = '{
        '{440,  69, 0, 0, 'h00,  0, 0},
        '{440,  69, 0, 0, 'h00,  0, 0},
        '{440,  69, 0, 1, 'h0C, 69, 1},
        '{440,  69, 0, 1, 'h0C, 69, 0},
        '{427,  68, 0, 1, 'h0C, 69, 0},
        '{428,  69, 0, 1, 'h0C, 69, 0},
        '{427,  68, 0, 1, 'h0C, 69, 0},
        '{427,  68, 0, 1, 'h0C, 69, 0},
        '{427,  68, 0, 1, 'h14, 68, 1},
        '{466,  70, 0, 1, 'h14, 68, 0},
        '{466,  70, 0, 1, 'h14, 68, 0},
        '{262,  60, 0, 1, 'h14, 68, 0},
        '{262,  60, 0, 1, 'h14, 68, 0},
        '{262,  60, 0, 1, 'h4C, 60, 1},
        '{100,   0, 1, 1, 'h4C, 60, 0},
        '{100,   0, 1, 1, 'h4C, 60, 0},
        '{100,   0, 1, 0, 'h00,  0, 1},
        '{100,   0, 1, 0, 'h00,  0, 0},
        '{1017,  0, 1, 0, 'h00,  0, 0},
        '{213,   0, 1, 0, 'h00,  0, 0},
        '{214,  57, 0, 0, 'h00,  0, 0},
        '{1016, 83, 0, 0, 'h00,  0, 0},
        '{1016, 83, 0, 0, 'h00,  0, 0},
        '{1016, 83, 0, 1, 'h2D, 83, 1}
    };

    // After the mid-search reset the filter starts from scratch.
    int post_vec [3][7] = '{
        '{262, 60, 0, 0, 'h00,  0, 0},
        '{262, 60, 0, 0, 'h00,  0, 0},
        '{262, 60, 0, 1, 'h4C, 60, 1}
    };

    function automatic exp_t mk_exp(input int r, input int o, input int v,
                                    input int c, input int m, input int ch);
        exp_t e;
        e.raw   = 7'(r);
        e.oor   = 1'(o);
        e.valid = 1'(v);
        e.code  = 8'(c);
        e.midi  = 7'(m);
        e.chg   = 1'(ch);
        return e;
    endfunction

    // ---------------- driver ----------------
    // Entered on a falling edge; returns on the falling edge after the acceptance edge,
    // leaving freq_valid_in high so consecutive calls form a continuous-valid stream.
    task automatic send(input int f, input exp_t e);
        int n;
        int acc;
        freq_in       = 16'(f);
        freq_valid_in = 1'b1;
        n = 0;
        while (!freq_ready_out && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        if (!freq_ready_out) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: freq=%0d ready still %0b after %0d cycles, required 1", f, freq_ready_out, n);
            return;
        end
        acc = cycle + 1;
        if (have_prev) begin
            checks++;
            if (n != 7) begin
                errors++;
                $display("FAIL ready_low_cycles: freq=%0d got %0d low cycles, required 7", f, n);
            end
            checks++;
            if (acc - prev_acc != 8) begin
                errors++;
                $display("FAIL accept_spacing: freq=%0d got %0d cycles, required 8", f, acc - prev_acc);
            end
        end
        prev_acc  = acc;
        have_prev = 1'b1;
        exp_q.push_back(e);
        acc_q.push_back(acc);
        @(negedge clk_in);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk_in);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: %0d results outstanding, required 0", tag, exp_q.size());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        logic [26:0] got;
        got = {freq_ready_out, raw_valid_out, raw_midi_out, raw_oor_out, note_valid_out,
               note_code_out, midi_out, note_changed_out};
        checks++;
        if (got != {1'b1, 26'd0}) begin
            errors++;
            $display("FAIL %s: got ready=%0b raw_v=%0b raw=%0d oor=%0b nv=%0b code=%h midi=%0d chg=%0b, required ready=1 and all others 0",
                     tag, freq_ready_out, raw_valid_out, raw_midi_out, raw_oor_out,
                     note_valid_out, note_code_out, midi_out, note_changed_out);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            checks++;
            if (note_changed_out && !raw_valid_out) begin
                errors++;
                $display("FAIL stray_change_pulse: note_changed_out=1 with raw_valid_out=0 at cycle %0d", cycle);
            end
            if (raw_valid_out) begin
                exp_t e;
                exp_t g;
                int   a;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: raw_valid_out=1 at cycle %0d with no sample outstanding", cycle);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    g = {raw_midi_out, raw_oor_out, note_valid_out, note_code_out, midi_out, note_changed_out};
                    if (g != e) begin
                        errors++;
                        $display("FAIL result: got raw=%0d oor=%0b nv=%0b code=%h midi=%0d chg=%0b, required raw=%0d oor=%0b nv=%0b code=%h midi=%0d chg=%0b",
                                 g.raw, g.oor, g.valid, g.code, g.midi, g.chg,
                                 e.raw, e.oor, e.valid, e.code, e.midi, e.chg);
                    end
                    checks++;
                    if (cycle - a != 7) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, required 7", cycle - a);
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        checks        = 0;
        errors        = 0;
        have_prev     = 1'b0;
        prev_acc      = 0;
        rst_n_in      = 1'b0;
        freq_valid_in = 1'b0;
        freq_in       = '0;
        #1;
        check_idle_outputs("reset_state");
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check_idle_outputs("after_release");

        foreach (vec[i]) begin
            send(vec[i][0], mk_exp(vec[i][1], vec[i][2], vec[i][3], vec[i][4], vec[i][5], vec[i][6]));
        end
        freq_valid_in = 1'b0;
        drain("main");

        // Abort a sample in the middle of its search.
        @(negedge clk_in);
        freq_in       = 16'd466;
        freq_valid_in = 1'b1;
        checks++;
        if (!freq_ready_out) begin
            errors++;
            $display("FAIL abort_ready: got ready=%0b before abort sample, required 1", freq_ready_out);
        end
        @(negedge clk_in);
        freq_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        check_idle_outputs("reset_mid_search");
        repeat (2) @(negedge clk_in);
        check_idle_outputs("reset_held");
        rst_n_in  = 1'b1;
        have_prev = 1'b0;
        repeat (10) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_queue: got %0d outstanding, required 0", exp_q.size());
        end

        foreach (post_vec[i]) begin
            send(post_vec[i][0], mk_exp(post_vec[i][1], post_vec[i][2], post_vec[i][3],
                                        post_vec[i][4], post_vec[i][5], post_vec[i][6]));
        end
        freq_valid_in = 1'b0;
        drain("post_reset");
        repeat (12) @(negedge clk_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_tracker.md
Name: note_tracker

Overview:
- Parametrised successor to the combinational frequency-to-note mapper in the pitch path.
- Quantises an integer-Hz frequency estimate to the nearest equal-tempered semitone over a configurable MIDI key window. Uses an iterative binary search against geometric-midpoint boundaries.
- Applies a consecutive-result stability filter before committing a note.
- Sits between the pitch detector and the display/scoring logic. Output keeps the established 8-bit note code: [7:5] letter (A=0…G=6), [4:3] accidental (01 natural, 10 flat), [2:0] scientific octave.

Parameters:
- FREQ_W, 16, input frequency width, unsigned integer Hz.
- LOW_KEY, 57, lowest MIDI key quantised (57 = A3). Must be ≥21.
- NUM_KEYS, 27, number of keys in the window. LOW_KEY+NUM_KEYS ≤ 108; elaboration error otherwise.
- STABLE_COUNT, 3, identical consecutive results required to commit (≥1; 1 = commit immediately).

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- freq_valid_in  input  1  frequency sample valid
- freq_in  input  FREQ_W  frequency in Hz
- freq_ready_out  output  1  high only in IDLE; sample accepted when valid && ready
- raw_valid_out  output  1  one-cycle pulse: search result available
- raw_midi_out  output  7  unfiltered MIDI key (0 when out of range)
- raw_oor_out  output  1  unfiltered out-of-range flag, qualified by raw_valid_out
- note_valid_out  output  1  committed note present
- note_code_out  output  8  committed note code
- midi_out  output  7  committed MIDI key
- note_changed_out  output  1  one-cycle pulse on every commit

Behaviour:
- Reset (async assert, sync release): state IDLE, freq_ready_out=1. All other outputs, candidate, counter and committed registers are 0.
- Boundary b[k] is the lower edge of key k, in 1/16 Hz units (20 bits): round(16·440·2^((k−69)/12 − 1/24)).
  - Input is scaled to f16 = freq_in<<4 for comparisons.
- FSM states: IDLE → CHECK → SEARCH (STEPS = $clog2(NUM_KEYS) cycles, fixed) → DONE → IDLE.
- IDLE: latch freq_in on acceptance.
- CHECK: out of range if f16 < b[LOW_KEY] or f16 ≥ b[LOW_KEY+NUM_KEYS]. Initialise lo=LOW_KEY, hi=LOW_KEY+NUM_KEYS.
- SEARCH: each cycle, if hi−lo>1 then mid=(lo+hi)>>1, and lo=mid if f16 ≥ b[mid], else hi=mid. Otherwise hold lo/hi. Result key = lo.
  - Out-of-range samples still run all SEARCH cycles, so latency is constant.
- DONE: pulse raw_valid_out and update the filter.
- Latency: raw_valid_out is high exactly STEPS+2 cycles after the acceptance edge (7 for defaults). Throughput is one sample per STEPS+3 cycles.
- freq_valid_in outside IDLE is ignored; it is not queued.
- Filter: the result value R is the MIDI key, or a distinct NONE value when out of range.
  - R == candidate: count saturates upward at STABLE_COUNT.
  - Otherwise: candidate=R, count=1.
  - Commit when count reaches STABLE_COUNT (this DONE cycle) and (R ≠ committed or note_valid_out=0).
    - Commit of a key: note_valid_out=1, update midi_out and note_code_out, pulse note_changed_out.
    - Commit of NONE with note_valid_out=1: note_valid_out=0, midi_out and note_code_out cleared to 0, pulse note_changed_out.
    - Commit of NONE with note_valid_out=0: no pulse.
  - Repeated commits of the same key produce no pulse.
- Encoding of key k: pc=k mod 12, octave=(k/12)−1.
  - pc 0..11 maps to C, Db, D, Eb, E, F, Gb, G, Ab, A, Bb, B.
  - Flats are used for all accidentals.
- Reset mid-search: abort immediately and return to IDLE. No raw_valid_out pulse is emitted.

Decomposition:
- Package note_pkg holds:
  - NOTE_LETTER_* and ACC_NATURAL / ACC_FLAT constants
  - note_code_t packed struct {letter[2:0], acc[1:0], octave[2:0]}
  - 88-entry boundary constant table for MIDI 21..108
  - function midi_to_note_code
- One sub-module, note_boundary_rom: combinational index→b[k] lookup, shared by the CHECK and SEARCH compares. Two read ports.

Test Plan:
- freq_in=440, STABLE_COUNT=1 → raw_midi_out=69 at acceptance+7 cycles; note_code_out=8'h0C (A, natural, 4); note_changed_out pulses once.
- Boundary: 427 → raw_midi_out=68, code 8'h14 (Ab4). 428 → raw_midi_out=69.
- Default STABLE_COUNT=3; samples 466,466,262,262,262 → commit Bb4 (8'h34) is never reached. Third 262 commits C4 (8'h4C) with one note_changed_out pulse.
- Committed A4; then three samples of 100 Hz → raw_oor_out=1 each; note_valid_out falls and note_changed_out pulses on the third sample only.
- Hold freq_valid_in high continuously → freq_ready_out low during CHECK, SEARCH and DONE; exactly one acceptance per 8 cycles.
- Assert rst_n_in mid-SEARCH → outputs 0 and freq_ready_out=1 immediately; no raw_valid_out pulse; next sample after release yields its normal result.
